irq_sched: RTL and testbench
============================

// Module: irq_sched
// PURPOSE
//   Interrupt request scheduler for the multicycle MIPS microsystem.
//   - Collects edge events from peripheral IRQ lines and holds them as pending bits.
//   - Applies the CP0 mask and global enable, then picks one winner.
//   - Drives intreq to the control unit. Completes the handshake with its
//     exception-entry (exlset) and eret (exlclr) strobes.
//   - Exports pending bits for CP0 Cause.IP and the winner ID for the handler.
// PARAMETERS
//   N_SRC  6  number of interrupt sources (2..8)
//   ID_W   3  width of irq_id; must satisfy 2**ID_W >= N_SRC
// PORTS
//   clk      in   1      system clock; all logic on posedge
//   reset    in   1      synchronous, active-low reset
//   irq_src  in   N_SRC  device IRQ lines, synchronous to clk; a rising edge is an event
//   im       in   N_SRC  CP0 SR.IM mask; 1 = source enabled
//   ie       in   1      CP0 SR.IE global interrupt enable
//   exl      in   1      CP0 SR.EXL; 1 = handler in progress
//   exlset   in   1      1-cycle strobe from the control unit: exception entry taken
//   exlclr   in   1      1-cycle strobe from the control unit: eret executed
//   intreq   out  1      interrupt request to the control unit
//   ip       out  N_SRC  pending bits, feed CP0 Cause.IP
//   irq_id   out  ID_W   index of the latched winner; stable from ASSERT through SERVICE
//   src_ack  out  N_SRC  one-hot, 1-cycle acknowledge pulse to the serviced device
// BEHAVIOUR
//   Reset (reset==0 at a posedge): state=IDLE; src_q, pend, irq_id, src_ack = 0;
//     intreq=0; ip=0. Any in-flight request or service is abandoned.
//   Edge detect: src_q <= irq_src each cycle.
//     rise = irq_src & ~src_q.
//     pend <= (pend & ~clr) | rise, where clr = src_ack.
//     Set wins when a rise and a clear hit the same bit in the same cycle.
//   ip = pend (registered). elig = pend & im, qualified by ie & ~exl.
//   FSM, state encoding in package:
//     IDLE    -> ASSERT when |elig. The winner index is latched into irq_id.
//     ASSERT  intreq=1.
//             -> SERVICE on exlset: src_ack[irq_id] pulses for exactly 1 cycle
//                and pend[irq_id] clears.
//             -> IDLE with no ack if elig[irq_id] drops before exlset
//                (masked, ie=0, or exl=1). intreq falls the next cycle.
//             exlset wins over a same-cycle withdrawal.
//     SERVICE intreq=0; waits for exlclr.
//             -> IDLE on exlclr; arbitration re-evaluates the following cycle.
//             New events keep accumulating in pend.
//   exlset outside ASSERT is ignored. exlclr outside SERVICE is ignored.
//   Latency: irq_src rises before edge E0 -> pend set at E0 -> ASSERT at E1.
//     intreq is high in the cycle after E1: 2 cycles, event to intreq.
//   Back-to-back: after exlclr, the next eligible source gives intreq
//     2 cycles after exlclr.
//   intreq and src_ack are registered, glitch-free outputs.
// CONFIGURATION
//   IRQ_ROUND_ROBIN_EN
//     Defined: rotating priority. The search starts at (last serviced id + 1)
//       mod N_SRC. The pointer resets to N_SRC-1, so source 0 wins first.
//       The pointer advances only on exlset.
//     Undefined: fixed priority, lowest index wins. No pointer register.
// STRUCTURE
//   irq_pkg: FSM state typedef/localparams (IDLE, ASSERT, SERVICE),
//     default N_SRC/ID_W, one-hot-to-index function.
//   One sub-module, irq_prio_enc: combinational eligible-vector -> winner index
//     plus a valid bit. It takes the rotate pointer as an input when
//     IRQ_ROUND_ROBIN_EN is defined.
// TESTING
//   Basic: im=6'h3F, ie=1, exl=0; pulse irq_src[2].
//     -> ip=6'h04 next cycle; intreq=1 two cycles after the edge; irq_id=2.
//     Then exlset -> src_ack=6'h04 for 1 cycle, ip=0.
//     Then exlclr -> IDLE, intreq stays 0.
//   Priority: irq_src[1] and irq_src[4] rise together.
//     Fixed: irq_id=1, then 4 after exlclr.
//     RR with pointer at 1: irq_id=4 first.
//   Mask withdraw: irq_src[3] pending, ASSERT; set im[3]=0 before exlset.
//     -> intreq=0 next cycle, no src_ack, ip still 6'h08.
//     Restore im[3]=1 -> intreq returns.
//   Set/clear collision: irq_src[0] rises again on the same edge src_ack[0] fires.
//     -> ip[0] stays 1.
//     A second request follows after exlclr.
//   Reset mid-service: in SERVICE with ip=6'h30, drive reset=0 for 1 cycle.
//     -> state IDLE, ip=0, intreq=0, irq_id=0.
//     A later exlclr causes no effect.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request scheduler.
// Holds the scheduler FSM state type, the default source count and ID
// width, and a one-hot to index helper used by the fixed-priority encoder.
package irq_pkg;

    localparam int DEF_N_SRC = 6;
    localparam int DEF_ID_W  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Converts a one-hot (or all-zero) vector of up to 8 bits into its index.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx[0] = |(oh & 8'hAA);
        idx[1] = |(oh & 8'hCC);
        idx[2] = |(oh & 8'hF0);
        return idx;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational winner selection over the eligible interrupt vector.
// Config macro IRQ_ROUND_ROBIN_EN: when defined, the search starts one
// past the rotate pointer and wraps; otherwise the lowest index wins.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic [N_SRC-1:0] elig,
`ifdef IRQ_ROUND_ROBIN_EN
    input  logic [ID_W-1:0]  ptr,
`endif
    output logic [ID_W-1:0]  id,
    output logic             vld
);

`ifdef IRQ_ROUND_ROBIN_EN

    localparam int unsigned NS = N_SRC;
    localparam int          IW = $clog2(N_SRC);

    logic [IW-1:0] sel;

    // Rotating search: first eligible source at or after ptr+1, modulo N_SRC.
    always_comb begin
        id  = '0;
        vld = 1'b0;
        sel = '0;
        for (int unsigned k = 0; k < NS; k++) begin
            sel = IW'((32'(ptr) + 32'd1 + k) % NS);
            if (!vld && elig[sel]) begin
                vld = 1'b1;
                id  = ID_W'(sel);
            end
        end
    end

`else

    logic [N_SRC-1:0] lowest;

    // Isolate the lowest set bit, then encode it as an index.
    always_comb begin
        lowest = elig & (~elig + N_SRC'(1));
        vld    = |elig;
        id     = ID_W'(onehot_to_idx(8'(lowest)));
    end

`endif

endmodule

// File: rtl/irq_sched.sv
// Interrupt request scheduler for the multicycle MIPS microsystem.
// Turns rising edges on peripheral IRQ lines into pending bits, masks them
// with SR.IM / SR.IE / SR.EXL, picks one winner and runs the intreq /
// exception-entry / eret handshake with the control unit.
// Config macro IRQ_ROUND_ROBIN_EN: rotating priority with a pointer that
// advances on exception entry; undefined gives fixed lowest-index-first.
module irq_sched
    import irq_pkg::*;
#(
    parameter int N_SRC = DEF_N_SRC,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [N_SRC-1:0] im,
    input  logic             ie,
    input  logic             exl,
    input  logic             exlset,
    input  logic             exlclr,
    output logic             intreq,
    output logic [N_SRC-1:0] ip,
    output logic [ID_W-1:0]  irq_id,
    output logic [N_SRC-1:0] src_ack
);

    irq_state_t       state;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] elig;
    logic             qual;
    logic [ID_W-1:0]  win_id;
    logic             win_vld;
`ifdef IRQ_ROUND_ROBIN_EN
    logic [ID_W-1:0]  ptr;
`endif

    assign rise = irq_src & ~src_q;
    assign qual = ie & ~exl;
    assign elig = pend & im & {N_SRC{qual}};
    assign ip   = pend;

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .elig (elig),
`ifdef IRQ_ROUND_ROBIN_EN
        .ptr  (ptr),
`endif
        .id   (win_id),
        .vld  (win_vld)
    );

    // Edge detection and pending accumulation; a new rise beats a same-cycle ack clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            src_q <= '0;
            pend  <= '0;
        end else begin
            src_q <= irq_src;
            pend  <= (pend & ~src_ack) | rise;
        end
    end

    // Request/service handshake FSM with registered intreq, src_ack and irq_id.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            intreq  <= 1'b0;
            irq_id  <= '0;
            src_ack <= '0;
`ifdef IRQ_ROUND_ROBIN_EN
            ptr     <= ID_W'(N_SRC - 1);
`endif
        end else begin
            src_ack <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state  <= ASSERT;
                        intreq <= 1'b1;
                        irq_id <= win_id;
                    end
                end
                ASSERT: begin
                    // exlset is checked first so entry wins over a same-cycle withdrawal.
                    if (exlset) begin
                        state   <= SERVICE;
                        intreq  <= 1'b0;
                        src_ack <= N_SRC'(1) << irq_id;
`ifdef IRQ_ROUND_ROBIN_EN
                        ptr     <= irq_id;
`endif
                    end else if (!elig[irq_id]) begin
                        state  <= IDLE;
                        intreq <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (exlclr) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    intreq <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the scheduler.
module tb_irq_sched;

    localparam int N = 6;
`ifdef IRQ_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] irq_src;
    logic [N-1:0] im;
    logic         ie;
    logic         exl;
    logic         exlset;
    logic         exlclr;
    logic         intreq;
    logic [N-1:0] ip;
    logic [2:0]   irq_id;
    logic [N-1:0] src_ack;

    int n_chk  = 0;
    int n_fail = 0;

    irq_sched #(
        .N_SRC (N),
        .ID_W  (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .im      (im),
        .ie      (ie),
        .exl     (exl),
        .exlset  (exlset),
        .exlclr  (exlclr),
        .intreq  (intreq),
        .ip      (ip),
        .irq_id  (irq_id),
        .src_ack (src_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Behavioural model: mode 0 = waiting, 1 = requesting, 2 = handler running.
    int  m_mode;
    int  m_id;
    int  m_ptr;
    int  m_ack;
    int  m_nack;
    int  m_win;
    bit  m_pend [N];
    bit  m_prev [N];
    bit  m_el   [N];

    function automatic int pick(input int ptr, input logic [N-1:0] el);
        int start;
        start = RR ? (ptr + 1) % N : 0;
        for (int k = 0; k < N; k++) begin
            if (el[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] pend_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [N-1:0] ack_vec();
        logic [N-1:0] v;
        v = '0;
        if (m_ack >= 0) v[m_ack] = 1'b1;
        return v;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0;
            m_id   = 0;
            m_ptr  = N - 1;
            m_ack  = -1;
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 1'b0;
                m_prev[i] = 1'b0;
            end
        end else begin
            logic [N-1:0] elv;
            for (int i = 0; i < N; i++) begin
                m_el[i] = m_pend[i] && im[i] && ie && !exl;
                elv[i]  = m_el[i];
            end
            m_nack = -1;
            if (m_mode == 0) begin
                m_win = pick(m_ptr, elv);
                if (m_win >= 0) begin
                    m_mode = 1;
                    m_id   = m_win;
                end
            end else if (m_mode == 1) begin
                if (exlset) begin
                    m_mode = 2;
                    m_nack = m_id;
                    m_ptr  = m_id;
                end else if (!m_el[m_id]) begin
                    m_mode = 0;
                end
            end else if (exlclr) begin
                m_mode = 0;
            end
            for (int i = 0; i < N; i++) begin
                m_pend[i] = (m_pend[i] && m_ack != i) || (irq_src[i] && !m_prev[i]);
                m_prev[i] = irq_src[i];
            end
            m_ack = m_nack;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("m_ip",      32'(ip),      32'(pend_vec()));
        check("m_intreq",  32'(intreq),  32'(m_mode == 1));
        check("m_irq_id",  32'(irq_id),  32'(m_id));
        check("m_src_ack", 32'(src_ack), 32'(ack_vec()));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at a negedge while requesting: one exlset cycle, then one exlclr cycle.
    task automatic service();
        exlset = 1'b1;
        cyc(1);
        exlset = 1'b0;
        exlclr = 1'b1;
        cyc(1);
        exlclr = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] v);
        irq_src = v;
        cyc(1);
        irq_src = '0;
    endtask

    initial begin
        reset   = 1'b0;
        irq_src = '0;
        im      = 6'h3F;
        ie      = 1'b1;
        exl     = 1'b0;
        exlset  = 1'b0;
        exlclr  = 1'b0;
        cyc(2);
        check("rst_ip",      32'(ip),      32'h0);
        check("rst_intreq",  32'(intreq),  32'h0);
        check("rst_irq_id",  32'(irq_id),  32'h0);
        check("rst_src_ack", 32'(src_ack), 32'h0);
        reset = 1'b1;
        cyc(1);

        // Basic single source
        irq_src = 6'h04;
        cyc(1);
        check("basic_ip", 32'(ip), 32'h04);
        check("basic_intreq_early", 32'(intreq), 32'h0);
        irq_src = '0;
        cyc(1);
        check("basic_intreq", 32'(intreq), 32'h1);
        check("basic_id", 32'(irq_id), 32'h2);
        exlset = 1'b1;
        cyc(1);
        exlset = 1'b0;
        check("basic_ack", 32'(src_ack), 32'h04);
        check("basic_intreq_svc", 32'(intreq), 32'h0);
        cyc(1);
        check("basic_ack_off", 32'(src_ack), 32'h0);
        check("basic_ip_clr", 32'(ip), 32'h0);
        exlclr = 1'b1;
        cyc(1);
        exlclr = 1'b0;
        cyc(2);
        check("basic_idle", 32'(intreq), 32'h0);

        // Two sources rising together
        pulse(6'h12);
        cyc(1);
        check("prio_first", 32'(irq_id), RR ? 32'h4 : 32'h1);
        check("prio_first_req", 32'(intreq), 32'h1);
        service();
        check("prio_gap", 32'(intreq), 32'h0);
        cyc(1);
        check("prio_second_req", 32'(intreq), 32'h1);
        check("prio_second", 32'(irq_id), RR ? 32'h1 : 32'h4);
        service();
        cyc(1);
        check("prio_ip_clr", 32'(ip), 32'h0);

        // Mask withdrawal before exception entry
        pulse(6'h08);
        cyc(1);
        check("mask_req", 32'(intreq), 32'h1);
        im = 6'h37;
        cyc(1);
        check("mask_drop", 32'(intreq), 32'h0);
        check("mask_noack", 32'(src_ack), 32'h0);
        check("mask_ip", 32'(ip), 32'h08);
        im = 6'h3F;
        cyc(1);
        check("mask_return", 32'(intreq), 32'h1);
        check("mask_id", 32'(irq_id), 32'h3);
        service();
        cyc(1);

        // Set/clear collision on source 0
        pulse(6'h01);
        cyc(1);
        check("coll_req", 32'(intreq), 32'h1);
        exlset = 1'b1;
        cyc(1);
        exlset  = 1'b0;
        check("coll_ack", 32'(src_ack), 32'h01);
        irq_src = 6'h01;
        cyc(1);
        irq_src = '0;
        check("coll_ip", 32'(ip), 32'h01);
        exlclr = 1'b1;
        cyc(1);
        exlclr = 1'b0;
        cyc(1);
        check("coll_rereq", 32'(intreq), 32'h1);
        check("coll_id", 32'(irq_id), 32'h0);
        service();
        cyc(1);

        // Reset in the middle of service
        pulse(6'h01);
        cyc(1);
        exlset = 1'b1;
        cyc(1);
        exlset  = 1'b0;
        irq_src = 6'h30;
        cyc(1);
        irq_src = '0;
        check("rsvc_ip", 32'(ip), 32'h30);
        check("rsvc_intreq", 32'(intreq), 32'h0);
        reset = 1'b0;
        cyc(1);
        reset = 1'b1;
        check("rsvc_ip0", 32'(ip), 32'h0);
        check("rsvc_intreq0", 32'(intreq), 32'h0);
        check("rsvc_id0", 32'(irq_id), 32'h0);
        exlclr = 1'b1;
        cyc(1);
        exlclr = 1'b0;
        cyc(2);
        check("rsvc_after", 32'(intreq), 32'h0);
        check("rsvc_after_ip", 32'(ip), 32'h0);

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) irq_src[i] = ~irq_src[i];
            end
            if ($urandom_range(0, 15) == 0) im = 6'($urandom);
            if ($urandom_range(0, 7) == 0)  im = 6'h3F;
            ie     = ($urandom_range(0, 9) != 0);
            exl    = ($urandom_range(0, 9) == 0);
            exlset = ($urandom_range(0, 3) == 0);
            exlclr = ($urandom_range(0, 3) == 0);
            reset  = ($urandom_range(0, 299) != 0);
            cyc(1);
        end
        reset  = 1'b1;
        exlset = 1'b0;
        exlclr = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
